// File: rtl/booth_divider.sv
// ----------------------------------------------------------------------------
// booth_divider
//   Sequential signed divider: 16-bit two's-complement dividend by 8-bit
//   two's-complement divisor, giving an 8-bit quotient (truncated toward
//   zero) and an 8-bit remainder (sign follows the dividend). A restoring
//   shift-subtract loop runs on operand magnitudes, one quotient bit per
//   cycle, followed by a sign-fix cycle. Fixed latency: done pulses 17
//   cycles after the edge that accepts start.
//
// Ports
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset
//   start      operation request, only honoured while idle
//   dividend   16-bit signed dividend, captured on accepted start
//   divisor    8-bit signed divisor, captured on accepted start
//   busy       high while an operation is in flight
//   done       one-cycle pulse, results valid from this cycle
//   quotient   8-bit signed quotient (low byte of true quotient on ovf)
//   remainder  8-bit signed remainder
//   ovf        true quotient outside -128..127
//   dz         divisor was zero
// ----------------------------------------------------------------------------
module booth_divider (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic [15:0] dividend,
    input  logic [7:0]  divisor,
    output logic        busy,
    output logic        done,
    output logic [7:0]  quotient,
    output logic [7:0]  remainder,
    output logic        ovf,
    output logic        dz
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        FIX  = 2'd2
    } state_t;

    state_t      state_r;
    logic [15:0] dvd_sh_r;    // dividend magnitude, consumed MSB first
    logic [8:0]  dvs_mag_r;   // divisor magnitude; 128 needs the 9th bit
    logic [7:0]  dvd_low_r;   // raw dividend low byte for the divide-by-zero result
    logic        sign_q_r;
    logic        sign_r_r;
    logic [15:0] q_acc_r;     // quotient magnitude accumulator
    logic [7:0]  part_r;      // partial remainder, always < |divisor| <= 128
    logic [3:0]  cnt_r;

    logic [8:0]  shifted_s;
    logic        ge_s;
    logic [7:0]  next_part_s;
    logic [7:0]  q_fix_s;
    logic [7:0]  r_fix_s;
    logic        ovf_fix_s;
    logic        dz_fix_s;

    // Magnitude of a 16-bit two's-complement value; -32768 maps to 16'h8000.
    function automatic logic [15:0] mag16(input logic [15:0] v);
        mag16 = v[15] ? (~v + 16'd1) : v;
    endfunction

    // Magnitude of an 8-bit two's-complement value, widened so -128 -> 128.
    function automatic logic [8:0] mag8(input logic [7:0] v);
        mag8 = v[7] ? {1'b0, (~v + 8'd1)} : {1'b0, v};
    endfunction

    // Conditional two's-complement negation of a byte.
    function automatic logic [7:0] neg8_if(input logic neg, input logic [7:0] v);
        neg8_if = neg ? (~v + 8'd1) : v;
    endfunction

    // One restoring step plus the sign-fix results for the FIX cycle.
    always_comb begin
        shifted_s = {part_r, dvd_sh_r[15]};
        ge_s      = (shifted_s >= dvs_mag_r);
        // Difference is below |divisor| <= 128, so 8-bit modular subtraction is exact.
        if (ge_s) begin
            next_part_s = shifted_s[7:0] - dvs_mag_r[7:0];
        end else begin
            next_part_s = shifted_s[7:0];
        end

        dz_fix_s = (dvs_mag_r == 9'd0);
        if (dz_fix_s) begin
            q_fix_s   = 8'h00;
            r_fix_s   = dvd_low_r;
            ovf_fix_s = 1'b0;
        end else begin
            // Low byte of the negated 16-bit quotient equals the negated low byte.
            q_fix_s   = neg8_if(sign_q_r, q_acc_r[7:0]);
            r_fix_s   = neg8_if(sign_r_r, part_r);
            ovf_fix_s = sign_q_r ? (q_acc_r > 16'd128) : (q_acc_r > 16'd127);
        end
    end

    // Control FSM, datapath registers and registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r   <= IDLE;
            dvd_sh_r  <= 16'd0;
            dvs_mag_r <= 9'd0;
            dvd_low_r <= 8'd0;
            sign_q_r  <= 1'b0;
            sign_r_r  <= 1'b0;
            q_acc_r   <= 16'd0;
            part_r    <= 8'd0;
            cnt_r     <= 4'd0;
            busy      <= 1'b0;
            done      <= 1'b0;
            quotient  <= 8'd0;
            remainder <= 8'd0;
            ovf       <= 1'b0;
            dz        <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state_r)
                IDLE: begin
                    if (start) begin
                        dvd_sh_r  <= mag16(dividend);
                        dvs_mag_r <= mag8(divisor);
                        dvd_low_r <= dividend[7:0];
                        sign_q_r  <= dividend[15] ^ divisor[7];
                        sign_r_r  <= dividend[15];
                        q_acc_r   <= 16'd0;
                        part_r    <= 8'd0;
                        cnt_r     <= 4'd0;
                        busy      <= 1'b1;
                        state_r   <= CALC;
                    end else begin
                        state_r   <= IDLE;
                    end
                end
                CALC: begin
                    part_r   <= next_part_s;
                    q_acc_r  <= {q_acc_r[14:0], ge_s};
                    dvd_sh_r <= {dvd_sh_r[14:0], 1'b0};
                    cnt_r    <= cnt_r + 4'd1;
                    if (cnt_r == 4'd15) begin
                        state_r <= FIX;
                    end else begin
                        state_r <= CALC;
                    end
                end
                FIX: begin
                    quotient  <= q_fix_s;
                    remainder <= r_fix_s;
                    ovf       <= ovf_fix_s;
                    dz        <= dz_fix_s;
                    done      <= 1'b1;
                    busy      <= 1'b0;
                    state_r   <= IDLE;
                end
                default: begin
                    busy    <= 1'b0;
                    state_r <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_booth_divider.sv
// ----------------------------------------------------------------------------
// tb_booth_divider
//   Self-checking bench for booth_divider: directed vector table, randomized
//   operands against an integer-arithmetic reference, back-to-back start,
//   and asynchronous reset in the middle of an operation.
// ----------------------------------------------------------------------------
module tb_booth_divider;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic [15:0] dividend;
    logic [7:0]  divisor;
    logic        busy;
    logic        done;
    logic [7:0]  quotient;
    logic [7:0]  remainder;
    logic        ovf;
    logic        dz;

    int checks;
    int failures;

    booth_divider dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .dividend  (dividend),
        .divisor   (divisor),
        .busy      (busy),
        .done      (done),
        .quotient  (quotient),
        .remainder (remainder),
        .ovf       (ovf),
        .dz        (dz)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] a;
        logic [7:0]  b;
        logic [7:0]  q;
        logic [7:0]  r;
        logic        ov;
        logic        z;
    } vec_t;

    vec_t vecs [8];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Reference: plain signed integer division (truncating), wrapped to 8 bits.
    task automatic model(input logic [15:0] a, input logic [7:0] b,
                         output logic [7:0] q, output logic [7:0] r,
                         output logic ov, output logic z);
        int ai, bi, qi, ri;
        ai = int'($signed(a));
        bi = int'($signed(b));
        if (bi == 0) begin
            q = 8'h00; r = a[7:0]; ov = 1'b0; z = 1'b1;
        end else begin
            qi = ai / bi;
            ri = ai % bi;
            q  = qi[7:0];
            r  = ri[7:0];
            ov = (qi > 127) || (qi < -128);
            z  = 1'b0;
        end
    endtask

    // Wait for done after an accepted start edge; returns cycles counted.
    task automatic wait_done(output int lat);
        lat = 0;
        for (int c = 1; c <= 40; c++) begin
            @(posedge clk);
            #1;
            if (busy && done) begin
                failures++;
                checks++;
                $display("FAIL busy_and_done: both high at cycle %0d", c);
            end
            if (done) begin
                lat = c;
                break;
            end
        end
        if (lat == 0) begin
            $display("FAIL done_timeout: no done within 40 cycles");
        end
    endtask

    task automatic check_result(input string tag, input logic [7:0] q, input logic [7:0] r,
                                input logic ov, input logic z);
        chk({tag, "_q"},   {24'd0, quotient},  {24'd0, q});
        chk({tag, "_r"},   {24'd0, remainder}, {24'd0, r});
        chk({tag, "_ovf"}, {31'd0, ovf},       {31'd0, ov});
        chk({tag, "_dz"},  {31'd0, dz},        {31'd0, z});
    endtask

    // One full operation; operands are scrambled right after the start edge.
    task automatic run_op(input string tag, input logic [15:0] a, input logic [7:0] b,
                          input logic [7:0] q, input logic [7:0] r,
                          input logic ov, input logic z);
        int lat;
        @(negedge clk);
        dividend = a;
        divisor  = b;
        start    = 1'b1;
        @(posedge clk);
        #1;
        start    = 1'b0;
        dividend = 16'($urandom);
        divisor  = 8'($urandom);
        chk({tag, "_busy"}, {31'd0, busy}, 32'd1);
        wait_done(lat);
        chk({tag, "_lat"}, lat, 32'd17);
        check_result(tag, q, r, ov, z);
    endtask

    initial begin
        logic [7:0]  mq, mr;
        logic        mo, mz;
        logic [15:0] ra;
        logic [7:0]  rb;
        int          lat;
        int          seen_done;

        checks   = 0;
        failures = 0;
        start    = 1'b0;
        dividend = 16'h0000;
        divisor  = 8'h00;
        rst_n    = 1'b0;

        vecs[0] = '{16'hEC78, 8'hCE, 8'h64, 8'h00, 1'b0, 1'b0};
        vecs[1] = '{16'hFFEF, 8'h05, 8'hFD, 8'hFE, 1'b0, 1'b0};
        vecs[2] = '{16'h0011, 8'hFB, 8'hFD, 8'h02, 1'b0, 1'b0};
        vecs[3] = '{16'h0384, 8'hF9, 8'h80, 8'h04, 1'b0, 1'b0};
        vecs[4] = '{16'h3F01, 8'h7F, 8'h7F, 8'h00, 1'b0, 1'b0};
        vecs[5] = '{16'h8000, 8'h80, 8'h00, 8'h00, 1'b1, 1'b0};
        vecs[6] = '{16'h8000, 8'h01, 8'h00, 8'h00, 1'b1, 1'b0};
        vecs[7] = '{16'h1234, 8'h00, 8'h00, 8'h34, 1'b0, 1'b1};

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_done", {31'd0, done}, 32'd0);
        check_result("rst", 8'h00, 8'h00, 1'b0, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;

        // Directed table
        for (int i = 0; i < 8; i++) begin
            run_op($sformatf("vec%0d", i), vecs[i].a, vecs[i].b,
                   vecs[i].q, vecs[i].r, vecs[i].ov, vecs[i].z);
        end

        // Outputs hold after done and done is a single pulse
        repeat (3) @(posedge clk);
        #1;
        chk("hold_done", {31'd0, done}, 32'd0);
        check_result("hold", 8'h00, 8'h34, 1'b0, 1'b1);

        // Randomized operands against the reference model
        for (int i = 0; i < 150; i++) begin
            ra = 16'($urandom);
            rb = 8'($urandom);
            if (i % 4 == 0) ra = {{8{ra[7]}}, ra[7:0]};
            if (i % 25 == 0) rb = 8'h00;
            if (i % 25 == 1) rb = 8'h80;
            if (i % 25 == 2) ra = 16'h8000;
            model(ra, rb, mq, mr, mo, mz);
            run_op($sformatf("rnd%0d", i), ra, rb, mq, mr, mo, mz);
        end

        // Back-to-back: start held high, second op captured at the edge after done
        @(negedge clk);
        dividend = 16'hEC78;
        divisor  = 8'hCE;
        start    = 1'b1;
        @(posedge clk);
        #1;
        dividend = 16'h7FFF;
        divisor  = 8'h03;
        wait_done(lat);
        chk("b2b1_lat", lat, 32'd17);
        check_result("b2b1", 8'h64, 8'h00, 1'b0, 1'b0);
        dividend = 16'hFFEF;
        divisor  = 8'h05;
        @(posedge clk);
        #1;
        chk("b2b2_busy", {31'd0, busy}, 32'd1);
        start    = 1'b0;
        dividend = 16'h0000;
        divisor  = 8'h00;
        wait_done(lat);
        chk("b2b2_lat", lat, 32'd17);
        check_result("b2b2", 8'hFD, 8'hFE, 1'b0, 1'b0);

        // Reset in the middle of an operation
        @(negedge clk);
        dividend = 16'h0384;
        divisor  = 8'hF9;
        start    = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (8) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_busy", {31'd0, busy}, 32'd0);
        chk("arst_done", {31'd0, done}, 32'd0);
        check_result("arst", 8'h00, 8'h00, 1'b0, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        seen_done = 0;
        for (int c = 0; c < 25; c++) begin
            @(posedge clk);
            #1;
            if (done) seen_done = 1;
        end
        chk("arst_no_done", seen_done, 32'd0);
        run_op("post_rst", 16'h0384, 8'hF9, 8'h80, 8'h04, 1'b0, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
